// File: rtl/mem_pkg.sv
// Shared memop encodings and FSM state type for the data-memory access unit.
// Build option: MISALIGN_TRAP_EN (see mem_req_check).
package mem_pkg;

  localparam logic [2:0] MEMOP_B    = 3'b000;
  localparam logic [2:0] MEMOP_H    = 3'b001;
  localparam logic [2:0] MEMOP_W    = 3'b010;
  localparam logic [2:0] MEMOP_BU   = 3'b100;
  localparam logic [2:0] MEMOP_HU   = 3'b101;
  localparam logic [2:0] MEMOP_IDLE = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_req_check.sv
// Request legality and alignment check.
// MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being aligned.
module mem_req_check
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              we,
  input  logic [2:0]        memop,
  input  logic [ADDR_W-1:0] addr,
  output logic              illegal,
  output logic [ADDR_W-1:0] addr_out
);

  logic is_half;
  logic is_word;
  logic bad_op;

  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    bad_op  = 1'b0;
    unique case (1'b1)
      (memop == MEMOP_B):  ;
      (memop == MEMOP_BU): bad_op = we;
      (memop == MEMOP_H):  is_half = 1'b1;
      (memop == MEMOP_HU): begin
        is_half = 1'b1;
        bad_op  = we;
      end
      (memop == MEMOP_W):  is_word = 1'b1;
      default:             bad_op = 1'b1;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;

  assign misalign = (is_half & addr[0])
                  | (is_word & (|addr[1:0]));
  assign illegal  = bad_op | misalign;
  assign addr_out = addr;
`else
  // Misaligned accesses are silently rounded down to the access size.
  assign illegal  = bad_op;
  assign addr_out = {addr[ADDR_W-1:2],
                     addr[1] & ~is_word,
                     addr[0] & ~(is_half | is_word)};
`endif

endmodule

// File: rtl/mem_access_unit.sv
// CPU-to-data-memory access unit: one outstanding request, registered memory side.
// MISALIGN_TRAP_EN selects trapping vs. aligning of misaligned accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_memop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_datain,
  output logic [2:0]        mem_memop,
  output logic              mem_we,
  input  logic [31:0]       mem_dataout
);

  state_t              state;
  state_t              state_nx;
  logic                up;
  logic                accept;
  logic                illegal;
  logic [ADDR_W-1:0]   addr_chk;
  logic                we_q;
  logic [2:0]          memop_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                fault_q;

  mem_req_check #(
    .ADDR_W(ADDR_W)
  ) u_check (
    .we      (req_we),
    .memop   (req_memop),
    .addr    (req_addr),
    .illegal (illegal),
    .addr_out(addr_chk)
  );

  // 'up' keeps req_ready low until the first edge after reset release.
  assign req_ready  = up & (state == IDLE);
  assign accept     = req_valid & req_ready;
  assign mem_addr   = 32'(addr_q);
  assign mem_datain = wdata_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_fault  = fault_q & (state == RESP);

  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_memop = MEMOP_IDLE;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = illegal ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_we    = we_q;
        mem_memop = memop_q;
        state_nx  = we_q ? RESP : WAIT;
      end
      WAIT: begin
        mem_memop = memop_q;
        state_nx  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      up      <= 1'b0;
      we_q    <= 1'b0;
      memop_q <= MEMOP_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nx;
      up    <= 1'b1;
      if (accept) begin
        we_q    <= req_we;
        memop_q <= req_memop;
        addr_q  <= addr_chk;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        fault_q <= illegal;
      end else if (state == WAIT) begin
        rdata_q <= mem_dataout;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a byte-array memory and reference model.
// Honours MISALIGN_TRAP_EN when choosing misaligned-access expectations.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_memop = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic [2:0]  mem_memop;
  logic        mem_we;
  logic [31:0] mem_dataout = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_memop  (req_memop),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .mem_addr   (mem_addr),
    .mem_datain (mem_datain),
    .mem_memop  (mem_memop),
    .mem_we     (mem_we),
    .mem_dataout(mem_dataout)
  );

  // Environment memory: 256 bytes, little endian, does its own extension.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       mem_init = 1'b1;
  logic [7:0] ma;
  assign ma = mem_addr[7:0];

  function automatic logic [7:0] seed_byte(int i);
    return 8'((i * 37 + 5) ^ 8'h5a);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed_byte(i);
    end else if (mem_we) begin
      case (mem_memop)
        MEMOP_B: mem[ma] <= mem_datain[7:0];
        MEMOP_H: begin
          mem[ma]          <= mem_datain[7:0];
          mem[8'(ma + 1)]  <= mem_datain[15:8];
        end
        MEMOP_W: begin
          mem[ma]          <= mem_datain[7:0];
          mem[8'(ma + 1)]  <= mem_datain[15:8];
          mem[8'(ma + 2)]  <= mem_datain[23:16];
          mem[8'(ma + 3)]  <= mem_datain[31:24];
        end
        default: ;
      endcase
    end
    case (mem_memop)
      MEMOP_B:  mem_dataout <= {{24{mem[ma][7]}}, mem[ma]};
      MEMOP_BU: mem_dataout <= {24'h0, mem[ma]};
      MEMOP_H:  mem_dataout <= {{16{mem[8'(ma + 1)][7]}},
                                mem[8'(ma + 1)], mem[ma]};
      MEMOP_HU: mem_dataout <= {16'h0, mem[8'(ma + 1)], mem[ma]};
      MEMOP_W:  mem_dataout <= {mem[8'(ma + 3)], mem[8'(ma + 2)],
                                mem[8'(ma + 1)], mem[ma]};
      default:  mem_dataout <= '0;
    endcase
  end

  // Reference model, stated in terms of access size and value arithmetic.
  function automatic int ref_size(logic [2:0] op);
    case (op)
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 1;
    endcase
  endfunction

  function automatic bit ref_illegal(logic we, logic [2:0] op, int a);
    bit bad;
    bad = !(op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (we && (op == 3'b100 || op == 3'b101)) bad = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (!bad && (a % ref_size(op)) != 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] op, int a);
    int sz;
    int base;
    longint v;
    sz   = ref_size(op);
    base = a - (a % sz);
    v    = 0;
    for (int k = 0; k < sz; k++)
      v += longint'(ref_mem[(base + k) % 256]) * (longint'(1) << (8 * k));
    if (op[2] == 1'b0 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v -= (longint'(1) << (8 * sz));
    return 32'(v);
  endfunction

  task automatic ref_store(logic [2:0] op, int a, logic [31:0] wd);
    int sz;
    int base;
    sz   = ref_size(op);
    base = a - (a % sz);
    for (int k = 0; k < sz; k++)
      ref_mem[(base + k) % 256] = 8'(wd >> (8 * k));
  endtask

  // Drive one request; return at #1 after the edge where rsp_valid shows.
  task automatic issue(input logic we, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output int wecnt,
                       output logic [31:0] maddr);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_memop = op;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fails++;
      $display("FAIL accept_timeout req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat   = 1;
    wecnt = 0;
    maddr = mem_addr;
    while (!rsp_valid && lat < 20) begin
      if (mem_we) wecnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      fails++;
      $display("FAIL rsp_timeout rsp_valid=%b required 1", rsp_valid);
    end
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_byte(i);
    rst_n    = 1'b0;
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_fault, mem_we} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl got %b required 0000",
               {req_ready, rsp_valid, rsp_fault, mem_we});
    end
    tests++;
    if ({rsp_rdata, mem_addr, mem_datain} !== 96'h0) begin
      fails++;
      $display("FAIL reset_data got %h required 0",
               {rsp_rdata, mem_addr, mem_datain});
    end
    tests++;
    if (mem_memop !== MEMOP_IDLE) begin
      fails++;
      $display("FAIL reset_memop got %b required 111", mem_memop);
    end
    @(negedge clk);
    mem_init = 1'b0;
    rst_n    = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge got %b required 0", req_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_edge got %b required 1", req_ready);
    end
  endtask

  task automatic test_load_word();
    int lat, wec;
    logic [31:0] ma_s;
    issue(1'b1, MEMOP_W, 32'h10, 32'hDEADBEEF, lat, wec, ma_s);
    ref_store(MEMOP_W, 32'h10, 32'hDEADBEEF);
    retire();
    issue(1'b0, MEMOP_W, 32'h10, 32'h0, lat, wec, ma_s);
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL load_latency got %0d required 3", lat);
    end
    tests++;
    if (rsp_rdata !== 32'hDEADBEEF || rsp_fault !== 1'b0) begin
      fails++;
      $display("FAIL load_word got %h/%b required deadbeef/0",
               rsp_rdata, rsp_fault);
    end
    retire();
  endtask

  task automatic test_store_load();
    int lat, wec;
    logic [31:0] ma_s;
    issue(1'b1, MEMOP_B, 32'h21, 32'h123456A5, lat, wec, ma_s);
    ref_store(MEMOP_B, 32'h21, 32'h123456A5);
    tests++;
    if (lat !== 2 || wec !== 1) begin
      fails++;
      $display("FAIL store_timing lat=%0d we=%0d required 2/1", lat, wec);
    end
    tests++;
    if (rsp_rdata !== 32'h0 || rsp_fault !== 1'b0) begin
      fails++;
      $display("FAIL store_rsp got %h/%b required 0/0", rsp_rdata, rsp_fault);
    end
    retire();
    issue(1'b0, MEMOP_B, 32'h21, 32'h0, lat, wec, ma_s);
    tests++;
    if (rsp_rdata !== 32'hFFFFFFA5) begin
      fails++;
      $display("FAIL load_byte_signed got %h required ffffffa5", rsp_rdata);
    end
    retire();
  endtask

  task automatic test_fault();
    int lat, wec;
    logic [31:0] ma_s;
    logic [31:0] exp;
    issue(1'b1, MEMOP_BU, 32'h30, 32'h000000FF, lat, wec, ma_s);
    tests++;
    if (lat !== 1 || wec !== 0 || rsp_fault !== 1'b1 || rsp_rdata !== 0) begin
      fails++;
      $display("FAIL fault_store lat=%0d we=%0d f=%b d=%h required 1/0/1/0",
               lat, wec, rsp_fault, rsp_rdata);
    end
    retire();
    exp = ref_load(MEMOP_BU, 32'h30);
    issue(1'b0, MEMOP_BU, 32'h30, 32'h0, lat, wec, ma_s);
    tests++;
    if (rsp_rdata !== exp) begin
      fails++;
      $display("FAIL fault_no_write got %h required %h", rsp_rdata, exp);
    end
    retire();
  endtask

  task automatic test_misaligned();
    int lat, wec;
    logic [31:0] ma_s;
    logic [31:0] exp;
    exp = ref_load(MEMOP_W, 32'h10);
    issue(1'b0, MEMOP_W, 32'h13, 32'h0, lat, wec, ma_s);
`ifdef MISALIGN_TRAP_EN
    tests++;
    if (lat !== 1 || rsp_fault !== 1'b1 || rsp_rdata !== 0) begin
      fails++;
      $display("FAIL misalign_trap lat=%0d f=%b d=%h required 1/1/0",
               lat, rsp_fault, rsp_rdata);
    end
`else
    tests++;
    if (ma_s !== 32'h10) begin
      fails++;
      $display("FAIL misalign_addr got %h required 10", ma_s);
    end
    tests++;
    if (lat !== 3 || rsp_fault !== 1'b0 || rsp_rdata !== exp) begin
      fails++;
      $display("FAIL misalign_data lat=%0d f=%b d=%h required 3/0/%h",
               lat, rsp_fault, rsp_rdata, exp);
    end
`endif
    retire();
  endtask

  task automatic test_backpressure();
    int lat, wec;
    logic [31:0] ma_s;
    logic [31:0] exp;
    exp = ref_load(MEMOP_H, 32'h40);
    issue(1'b0, MEMOP_H, 32'h40, 32'h0, lat, wec, ma_s);
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure c=%0d v=%b d=%h r=%b required 1/%h/0",
                 c, rsp_valid, rsp_rdata, req_ready, exp);
      end
      @(posedge clk);
      #1;
    end
    retire();
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_memop !== MEMOP_IDLE) begin
      fails++;
      $display("FAIL after_retire r=%b v=%b op=%b required 1/0/111",
               req_ready, rsp_valid, mem_memop);
    end
  endtask

  task automatic test_reset_access();
    int lat, wec;
    logic [31:0] ma_s;
    logic [31:0] exp;
    int seen;
    exp = ref_load(MEMOP_W, 32'h48);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_memop = MEMOP_W;
    req_addr  = 32'h48;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tests++;
    if (mem_we !== 1'b1) begin
      fails++;
      $display("FAIL rst_access_pre mem_we=%b required 1", mem_we);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_access_drop we=%b v=%b required 0/0", mem_we, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    tests++;
    if (seen !== 0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_access_after valid_cycles=%0d r=%b required 0/1",
               seen, req_ready);
    end
    issue(1'b0, MEMOP_W, 32'h48, 32'h0, lat, wec, ma_s);
    tests++;
    if (rsp_rdata !== exp) begin
      fails++;
      $display("FAIL rst_access_nowrite got %h required %h", rsp_rdata, exp);
    end
    retire();
  endtask

  task automatic test_random();
    int lat, wec;
    logic [31:0] ma_s;
    logic        we;
    logic [2:0]  op;
    int          a;
    logic [31:0] wd;
    bit          bad;
    logic [31:0] exp_d;
    int          exp_lat;
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      wd = $urandom;
      bad     = ref_illegal(we, op, a);
      exp_lat = bad ? 1 : (we ? 2 : 3);
      exp_d   = (bad || we) ? 32'h0 : ref_load(op, a);
      issue(we, op, 32'(a), wd, lat, wec, ma_s);
      tests++;
      if (rsp_fault !== bad || rsp_rdata !== exp_d) begin
        fails++;
        $display("FAIL rand_rsp t=%0d we=%b op=%b a=%h f=%b d=%h required %b/%h",
                 t, we, op, a, rsp_fault, rsp_rdata, bad, exp_d);
      end
      tests++;
      if (lat !== exp_lat || wec !== ((we && !bad) ? 1 : 0)) begin
        fails++;
        $display("FAIL rand_timing t=%0d lat=%0d we=%0d required %0d/%0d",
                 t, lat, wec, exp_lat, (we && !bad) ? 1 : 0);
      end
      if (we && !bad) ref_store(op, a, wd);
      retire();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_word();
    test_store_load();
    test_fault();
    test_misaligned();
    test_backpressure();
    test_reset_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
